// File: rtl/sequencer_pkg.sv
// sequencer_pkg: shared sequencer LUT word layout, state codes, loader states and checksum helper.
package sequencer_pkg;
  localparam int LUT_DATA_W = 29;
  localparam int LUT_ADDR_W = 8;
  typedef enum logic [2:0] {SEQ_RST, SEQ_FETCH, SEQ_SOF, SEQ_DATA, SEQ_REPEAT, SEQ_EOF, SEQ_NEXT, SEQ_HALT} seq_state_e;
  typedef struct packed {
    logic        sof;
    logic        eof;
    logic [15:0] data_length;
    logic [7:0]  repeat_count;
    logic [2:0]  next_state;
  } lut_word_t;
  typedef enum logic [2:0] {LD_IDLE, LD_CLEAR, LD_WRITE, LD_RCLEAR, LD_READ, LD_RDRAIN, LD_DONE, LD_ERROR} ld_state_e;
  function automatic logic [15:0] csum_add(input logic [15:0] sum, input logic [LUT_DATA_W-1:0] word);
    return sum + word[15:0] + {3'b000, word[28:16]};
  endfunction
endpackage

// File: rtl/lut_checksum16.sv
// lut_checksum16: 16-bit wrapping checksum accumulator with clear and enable.
module lut_checksum16 import sequencer_pkg::*; (
  input  logic                  clk,
  input  logic                  reset_n_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [LUT_DATA_W-1:0] word_i,
  output logic [15:0]           sum_o
);
  logic [15:0] sum_q, sum_d;
  always_comb sum_d = clr_i ? 16'h0 : en_i ? csum_add(sum_q, word_i) : sum_q;
  always_ff @(posedge clk) begin
    if (!reset_n_i) sum_q <= '0;
    else sum_q <= sum_d;
  end
  assign sum_o = sum_q;
endmodule

// File: rtl/sequencer_lut_loader.sv
// sequencer_lut_loader: streams command words into the sequencer LUT while holding it in reset.
// Define SEQ_LUT_VERIFY_EN to read the table back and gate completion on a checksum match.
module sequencer_lut_loader import sequencer_pkg::*; #(
  parameter int DATA_W     = LUT_DATA_W,
  parameter int ADDR_W     = LUT_ADDR_W,
  parameter int CLR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic              cmd_last_i,
  output logic              seq_reset_o,
  output logic              lut_wen_o,
  output logic [DATA_W-1:0] lut_write_data_o,
  output logic              lut_rden_o,
  input  logic [DATA_W-1:0] lut_read_data_i,
  output logic              busy_o,
  output logic              load_done_o,
  output logic              load_error_o,
  output logic [ADDR_W:0]   entry_count_o,
  output logic [15:0]       checksum_o
);
  localparam logic [ADDR_W:0] MAX_ENTRIES = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [7:0] CLR_LOAD = 8'(CLR_CYCLES - 1);
  ld_state_e state_q, state_d;
  logic [7:0] clr_q, clr_d;
  logic [ADDR_W:0] entry_q, entry_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic wlast_q, wlast_d, wen_q, wen_d, ready_q, ready_d, seq_rst_q, seq_rst_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic start, beat;
  assign start = start_i && (state_q inside {LD_IDLE, LD_DONE, LD_ERROR});
  assign beat = cmd_valid_i && ready_q;
`ifdef SEQ_LUT_VERIFY_EN
  logic [ADDR_W:0] rcnt_q, rcnt_d;
  logic rden_q, rden_d, rvalid_q, rvalid_d;
  logic [15:0] rd_sum;
  logic rd_match;
  always_comb begin
    rcnt_d = (state_q == LD_READ) ? rcnt_q - 1'b1 : entry_q;
    rden_d = (state_d == LD_READ);
    rvalid_d = rden_q;
  end
  // The last readback word is still on the bus in RDRAIN, so fold it in here.
  assign rd_match = csum_add(rd_sum, lut_read_data_i) == checksum_o;
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      rcnt_q <= '0;
      rden_q <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      rden_q <= rden_d;
      rvalid_q <= rvalid_d;
    end
  end
  lut_checksum16 u_rd_sum (.clk(clk), .reset_n_i(reset_n_i), .clr_i(start), .en_i(rvalid_q),
                           .word_i(lut_read_data_i), .sum_o(rd_sum));
  assign lut_rden_o = rden_q;
`else
  logic unused_read_data;
  assign unused_read_data = ^lut_read_data_i;
  assign lut_rden_o = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    clr_d = clr_q;
    entry_d = entry_q;
    wdata_d = wdata_q;
    wlast_d = 1'b0;
    wen_d = 1'b0;
    if (start) begin
      state_d = LD_CLEAR;
      clr_d = CLR_LOAD;
      entry_d = '0;
    end else begin
      case (state_q)
        LD_CLEAR: begin
          state_d = (clr_q == 0) ? LD_WRITE : LD_CLEAR;
          clr_d = clr_q - 1'b1;
        end
        LD_WRITE:
          // wlast_q marks the cycle the final strobe is out; leave only after it.
          if (wlast_q) begin
`ifdef SEQ_LUT_VERIFY_EN
            state_d = LD_RCLEAR;
`else
            state_d = LD_DONE;
`endif
            clr_d = CLR_LOAD;
          end else if (beat) begin
            if (entry_q == MAX_ENTRIES) state_d = LD_ERROR;
            else begin
              wen_d = 1'b1;
              wdata_d = cmd_data_i;
              entry_d = entry_q + 1'b1;
              wlast_d = cmd_last_i;
            end
          end
`ifdef SEQ_LUT_VERIFY_EN
        LD_RCLEAR: begin
          state_d = (clr_q == 0) ? LD_READ : LD_RCLEAR;
          clr_d = clr_q - 1'b1;
        end
        LD_READ: state_d = (rcnt_q == 1) ? LD_RDRAIN : LD_READ;
        LD_RDRAIN: state_d = rd_match ? LD_DONE : LD_ERROR;
`endif
        default: ;
      endcase
    end
    ready_d = (state_d == LD_WRITE) && !wlast_d;
    seq_rst_d = (state_d != LD_DONE);
    busy_d = !(state_d inside {LD_IDLE, LD_DONE, LD_ERROR});
    done_d = (state_d == LD_DONE) && (state_q != LD_DONE);
    err_d = (state_d == LD_ERROR);
  end
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state_q <= LD_IDLE;
      clr_q <= '0;
      entry_q <= '0;
      wdata_q <= '0;
      wlast_q <= 1'b0;
      wen_q <= 1'b0;
      ready_q <= 1'b0;
      seq_rst_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      entry_q <= entry_d;
      wdata_q <= wdata_d;
      wlast_q <= wlast_d;
      wen_q <= wen_d;
      ready_q <= ready_d;
      seq_rst_q <= seq_rst_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  lut_checksum16 u_wr_sum (.clk(clk), .reset_n_i(reset_n_i), .clr_i(start), .en_i(wen_d),
                           .word_i(cmd_data_i), .sum_o(checksum_o));
  assign cmd_ready_o = ready_q;
  assign seq_reset_o = seq_rst_q;
  assign lut_wen_o = wen_q;
  assign lut_write_data_o = wdata_q;
  assign busy_o = busy_q;
  assign load_done_o = done_q;
  assign load_error_o = err_q;
  assign entry_count_o = entry_q;
endmodule

// File: tb/tb_sequencer_lut_loader.sv
// tb_sequencer_lut_loader: randomized loads against a table-level model with a queue scoreboard.
module tb_sequencer_lut_loader;
`ifdef SEQ_LUT_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  logic clk = 1'b0, reset_n_i = 1'b0, start_i = 1'b0, cmd_valid_i = 1'b0, cmd_last_i = 1'b0;
  logic [28:0] cmd_data_i = '0, lut_read_data_i = '0;
  logic cmd_ready_o, seq_reset_o, lut_wen_o, lut_rden_o, busy_o, load_done_o, load_error_o;
  logic [28:0] lut_write_data_o;
  logic [8:0] entry_count_o;
  logic [15:0] checksum_o;

  sequencer_lut_loader dut (
    .clk(clk), .reset_n_i(reset_n_i), .start_i(start_i), .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o), .cmd_data_i(cmd_data_i), .cmd_last_i(cmd_last_i),
    .seq_reset_o(seq_reset_o), .lut_wen_o(lut_wen_o), .lut_write_data_o(lut_write_data_o),
    .lut_rden_o(lut_rden_o), .lut_read_data_i(lut_read_data_i), .busy_o(busy_o),
    .load_done_o(load_done_o), .load_error_o(load_error_o), .entry_count_o(entry_count_o),
    .checksum_o(checksum_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit err;
    int cnt;
    logic [15:0] csum;
    int rds;
  } res_t;

  int checks = 0, failures = 0, res_seen = 0;
  logic [28:0] exp_wq[$];
  res_t exp_rq[$];
  logic [28:0] tbl[$];
  logic [8:0] corrupt_idx = 9'h1FF;

  // Sequencer LUT stub: address resets while held in a clear pass, optional bit-5 corruption on readback.
  logic [28:0] mem[0:255];
  logic [8:0] wptr = '0, rptr = '0;
  always @(posedge clk) begin
    if (lut_wen_o) begin
      mem[wptr[7:0]] <= lut_write_data_o;
      wptr <= wptr + 9'd1;
    end
    if (lut_rden_o) begin
      lut_read_data_i <= mem[rptr[7:0]] ^ ((rptr == corrupt_idx) ? 29'h20 : 29'h0);
      rptr <= rptr + 9'd1;
    end
    if (busy_o && seq_reset_o && !cmd_ready_o && !lut_wen_o && !lut_rden_o) begin
      wptr <= '0;
      rptr <= '0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    logic done_prev = 1'b0, err_prev = 1'b0;
    int rds = 0;
    res_t r;
    forever begin
      @(negedge clk);
      if (lut_wen_o) begin
        if (exp_wq.size() == 0) chk("unexpected_write", 1, 0);
        else chk("write_data", lut_write_data_o, exp_wq.pop_front());
      end
      if (lut_wen_o || lut_rden_o) chk("strobe_overlap", lut_wen_o & lut_rden_o, 0);
      if (lut_rden_o) rds++;
      if (done_prev) chk("done_pulse_len", load_done_o, 0);
      if (load_done_o || (load_error_o && !err_prev)) begin
        if (exp_rq.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          r = exp_rq.pop_front();
          chk("result_error", load_error_o, r.err);
          chk("result_done", load_done_o, !r.err);
          chk("entry_count", entry_count_o, r.cnt);
          chk("checksum", checksum_o, r.csum);
          chk("seq_reset", seq_reset_o, r.err);
          chk("busy_end", busy_o, 0);
          chk("writes_pending", exp_wq.size(), 0);
          chk("read_strobes", rds, r.rds);
        end
        rds = 0;
        res_seen++;
      end
      done_prev = load_done_o;
      err_prev = load_error_o;
    end
  end

  task automatic send_beat(input logic [28:0] w, input bit last, input int gap, input bit poke);
    int t = 0;
    repeat (gap) @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_data_i = w;
    cmd_last_i = last;
    start_i = poke;
    while (!cmd_ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("beat_accept", cmd_ready_o, 1);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    cmd_last_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("start_entry_clr", entry_count_o, 0);
    chk("start_csum_clr", checksum_o, 0);
    chk("start_err_clr", load_error_o, 0);
    chk("start_busy", busy_o, 1);
  endtask

  task automatic run_load(input bit with_last, input int gap_min, input int gap_max, input int corrupt, input int poke);
    int n = tbl.size();
    int nw = (n > 256) ? 256 : n;
    int cs = 0, seen = res_seen, t = 0;
    res_t r;
    for (int i = 0; i < nw; i++) begin
      exp_wq.push_back(tbl[i]);
      cs = (cs + int'(tbl[i][15:0]) + int'(tbl[i][28:16])) % 65536;
    end
    r.err = (n > 256) || (VERIFY && corrupt >= 0 && corrupt < n);
    r.cnt = nw;
    r.csum = 16'(cs);
    r.rds = (VERIFY && n <= 256) ? n : 0;
    exp_rq.push_back(r);
    corrupt_idx = (corrupt >= 0) ? 9'(corrupt) : 9'h1FF;
    start_pulse();
    for (int i = 0; i < n; i++)
      send_beat(tbl[i], with_last && (i == n - 1), $urandom_range(gap_max, gap_min), i == poke);
    while (res_seen == seen && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("result_seen", res_seen != seen, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_table(input int n);
    tbl.delete();
    for (int i = 0; i < n; i++) tbl.push_back(29'($urandom));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_seq_reset", seq_reset_o, 1);
    chk("rst_wen", lut_wen_o, 0);
    chk("rst_rden", lut_rden_o, 0);
    chk("rst_ready", cmd_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", load_done_o, 0);
    chk("rst_error", load_error_o, 0);
    chk("rst_entries", entry_count_o, 0);
    chk("rst_checksum", checksum_o, 0);
    reset_n_i = 1'b1;
    @(negedge clk);
    tbl = {29'h1000_0802, 29'h0000_1003, 29'h0800_1807};
    run_load(1'b1, 0, 0, -1, -1);
    run_load(1'b1, 0, 0, 1, -1);
    rand_table(10);
    run_load(1'b1, 2, 2, -1, 4);
    rand_table(257);
    run_load(1'b0, 0, 0, -1, -1);
    rand_table(5);
    run_load(1'b1, 0, 1, -1, -1);
    rand_table(5);
    for (int i = 0; i < 3; i++) exp_wq.push_back(tbl[i]);
    start_pulse();
    for (int i = 0; i < 3; i++) send_beat(tbl[i], 1'b0, 0, 1'b0);
    reset_n_i = 1'b0;
    @(negedge clk);
    reset_n_i = 1'b1;
    chk("midrst_seq_reset", seq_reset_o, 1);
    chk("midrst_wen", lut_wen_o, 0);
    chk("midrst_ready", cmd_ready_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_entries", entry_count_o, 0);
    chk("midrst_checksum", checksum_o, 0);
    chk("midrst_pending", exp_wq.size(), 0);
    rand_table(4);
    run_load(1'b1, 0, 0, -1, -1);
    for (int k = 0; k < 6; k++) begin
      int n = $urandom_range(20, 1);
      rand_table(n);
      run_load(1'b1, 0, 2, ($urandom_range(2, 0) == 0) ? $urandom_range(n - 1, 0) : -1, $urandom_range(n - 1, 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/sequencer_lut_loader.md
# sequencer_lut_loader

Host-side loader for the sequencer's command LUT: accepts a stream of 29-bit command words, writes them into the sequencer LUT through its write-enable/auto-increment port while holding the sequencer in RST, optionally reads the whole table back to verify it, then releases the sequencer to run. Sits between the host register/stream bridge and the sequencer FSM's `lut_*` configuration port.

## Interface
- `DATA_W`, 29, LUT word width: sof[28], eof[27], data_length[26:11], repeat_count[10:3], next_state[2:0]
- `ADDR_W`, 8, LUT address width; maximum entries = 2**ADDR_W
- `CLR_CYCLES`, 2, cycles `seq_reset_o` is forced high before each write or read pass

- `clk` in 1: single clock domain
- `reset_n_i` in 1: reset, synchronous, active-low
- `start_i` in 1: begin a load; sampled only in IDLE/DONE/ERROR
- `cmd_valid_i` in 1: command word valid
- `cmd_ready_o` out 1: loader accepts word this cycle
- `cmd_data_i` in DATA_W: command word
- `cmd_last_i` in 1: final word of the table
- `seq_reset_o` out 1: active-high reset to the sequencer; holds it in RST during load
- `lut_wen_o` out 1: LUT write strobe; sequencer auto-increments its address per strobe
- `lut_write_data_o` out DATA_W: LUT write data
- `lut_rden_o` out 1: LUT read strobe; auto-increments address
- `lut_read_data_i` in DATA_W: sequencer read data, valid 1 cycle after `lut_rden_o`
- `busy_o` out 1: high in any state other than IDLE/DONE/ERROR
- `load_done_o` out 1: one-cycle pulse on successful completion
- `load_error_o` out 1: sticky; cleared by next accepted `start_i`
- `entry_count_o` out ADDR_W+1: entries written in current/last load
- `checksum_o` out 16: running checksum of written words

## Operation
- States: IDLE, CLEAR, WRITE, RCLEAR, READ, RDRAIN, DONE, ERROR.
- IDLE --start_i--> CLEAR: clear entry count and checksums, `seq_reset_o`=1 for CLR_CYCLES cycles (resets sequencer address to 0) -> WRITE.
- WRITE: `cmd_ready_o`=1; each accepted beat (valid&ready) increments `entry_count_o`, adds word to checksum; `seq_reset_o` stays 1. Beat with `cmd_last_i` -> RCLEAR (VERIFY) or DONE (no VERIFY).
- Overflow: beat accepted when `entry_count_o` == 2**ADDR_W -> not written, ERROR.
- RCLEAR: CLR_CYCLES cycles, address back to 0 -> READ.
- READ: `lut_rden_o`=1 for exactly `entry_count_o` consecutive cycles -> RDRAIN (1 cycle) capturing last data; each returned word added to readback checksum.
- RDRAIN end: readback checksum == `checksum_o` -> DONE, else ERROR.
- DONE: `seq_reset_o`=0 (sequencer runs from address 0), `load_done_o` pulses on entry.
- ERROR: `seq_reset_o` held 1, `load_error_o`=1.
- `start_i` in DONE/ERROR -> CLEAR; `start_i` while busy ignored.
- Checksum: 16-bit, wraps: sum += word[15:0] + {3'b0, word[28:16]} mod 2**16.

## Timing
- Reset values: `seq_reset_o`=1, all strobes 0, `cmd_ready_o`=0, `busy_o`=0, `load_done_o`=0, `load_error_o`=0, counts/checksum 0; state IDLE.
- Beat accepted cycle N -> `lut_wen_o`=1 with registered data at N+1; throughput one word/cycle.
- `lut_wen_o` and `lut_rden_o` never high together; neither high while CLEAR/RCLEAR counting.
- Last beat at N -> final write at N+1; RCLEAR starts N+2 (strobe never overlaps reset pulse).
- Read strobe at M -> data captured at M+1.
- `cmd_valid_i` outside WRITE ignored; `cmd_ready_o` low.
- `reset_n_i` low mid-load: abort at next edge, return to reset values (sequencer held in reset); LUT content undefined.

## Configuration
- `SEQ_LUT_VERIFY_EN` defined: RCLEAR/READ/RDRAIN present, checksum compare gates DONE.
- Undefined: WRITE -> DONE directly after last write strobe; `lut_rden_o` tied 0; `lut_read_data_i` unused; mismatch error impossible (overflow error remains).

## Structure
- Shared package `sequencer_pkg`: state-code localparams for the sequencer, LUT field offsets/widths, `DATA_W`/`ADDR_W` defaults, loader state enum, checksum function.
- One sub-module natural: `lut_checksum16` (accumulator with clear/enable), instantiated twice (write and readback).

## Test plan
- 3-word table 0x1000_0802, 0x0000_1003, 0x0800_1807 (last) -> 3 write strobes N+1..N+3, `entry_count_o`=3, `seq_reset_o` falls in DONE, `load_done_o` one pulse.
- Same table with VERIFY, model echoes stored data -> exactly 3 `lut_rden_o` cycles, DONE; corrupt word 1 by flipping bit 5 -> ERROR, `seq_reset_o` stays 1.
- Bursty valid (1 of 3 cycles) for 10 words -> 10 strobes, data order preserved, checksum equals model.
- 257 words without last (ADDR_W=8) -> 256 writes, ERROR on 257th beat, no 257th strobe.
- `reset_n_i` low for 1 cycle mid-WRITE -> next cycle all outputs at reset values; `start_i` then restarts with `entry_count_o`=0.
- `start_i` pulsed during WRITE -> ignored; `start_i` in ERROR -> CLEAR, `load_error_o` cleared.
